// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
// Operand-mux select encodings are reused by the execute-stage datapath.
package fwd_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] writereg;
      logic       regwrite;
      logic       memtoreg;
      logic       is_div;
   } stage_tag_t;

   localparam stage_tag_t TAG_NONE = '0;

   // The nearer producer (E, landing in M) wins over the farther one.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input stage_tag_t e,
                                          input stage_tag_t m);
      logic [1:0] sel;
      sel = FWD_REG;
      if (src == 5'd0) begin
         sel = FWD_REG;
      end else if (e.valid && e.regwrite && e.writereg == src) begin
         sel = FWD_MEM;
      end else if (m.valid && m.regwrite && m.writereg == src) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side hazard bundle: D-stage operand/destination info in,
// operand selects and pipeline stall/flush controls out.
interface fwd_hazard_ctrl_if;
   import fwd_pkg::*;

   logic       id_valid;
   logic [4:0] rs_d;
   logic [4:0] rt_d;
   logic [4:0] id_writereg;
   logic       id_regwrite;
   logic       id_memtoreg;
   logic       id_div;

   logic [1:0] forward_ae;
   logic [1:0] forward_be;
   logic       stall_f;
   logic       stall_d;
   logic       stall_e;
   logic       flush_e;
   logic       flush_m;
   logic       div_busy;
   stage_tag_t wb_tag;

   modport master (
      output id_valid, rs_d, rt_d, id_writereg,
      output id_regwrite, id_memtoreg, id_div,
      input  forward_ae, forward_be,
      input  stall_f, stall_d, stall_e,
      input  flush_e, flush_m, div_busy, wb_tag
   );

   modport slave (
      input  id_valid, rs_d, rt_d, id_writereg,
      input  id_regwrite, id_memtoreg, id_div,
      output forward_ae, forward_be,
      output stall_f, stall_d, stall_e,
      output flush_e, flush_m, div_busy, wb_tag
   );

endinterface

// File: rtl/div_stall_counter.sv
// Down-counter that keeps busy high for DIV_CYCLES cycles after start.
module div_stall_counter #(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   output logic busy
);

   localparam int CW = $clog2(DIV_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard controller: tracks E/M/W destination tags,
// registers operand selects, inserts load-use bubbles and divide freezes.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic             clk,
   input  logic             resetn,
   fwd_hazard_ctrl_if.slave hz
);

   stage_tag_t e_q, e_d;
   stage_tag_t m_q, m_d;
   stage_tag_t w_q, w_d;
   logic [1:0] fa_q, fa_d;
   logic [1:0] fb_q, fb_d;

   logic busy;
   logic load_use;
   logic start;
   logic stall_f, stall_d, stall_e;
   logic flush_e, flush_m;
   stage_tag_t d_tag;

   assign d_tag = '{valid:    hz.id_valid,
                    writereg: hz.id_writereg,
                    regwrite: hz.id_regwrite,
                    memtoreg: hz.id_memtoreg,
                    is_div:   hz.id_div};

   assign load_use = hz.id_valid && e_q.valid
                  && e_q.memtoreg && e_q.regwrite
                  && (e_q.writereg != 5'd0)
                  && (e_q.writereg == hz.rs_d ||
                      e_q.writereg == hz.rt_d);

   always_comb begin
      e_d     = d_tag;
      m_d     = e_q;
      w_d     = m_q;
      fa_d    = fwd_sel(hz.rs_d, e_q, m_q);
      fb_d    = fwd_sel(hz.rt_d, e_q, m_q);
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      start   = 1'b0;
      if (busy) begin
         // Divide owns E: hold it and its selects, drain M with a bubble.
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         flush_m = 1'b1;
         e_d     = e_q;
         m_d     = TAG_NONE;
         fa_d    = fa_q;
         fb_d    = fb_q;
      end else if (load_use) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
         e_d     = TAG_NONE;
         fa_d    = FWD_REG;
         fb_d    = FWD_REG;
      end else begin
         start = hz.id_valid && hz.id_div;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q  <= TAG_NONE;
         m_q  <= TAG_NONE;
         w_q  <= TAG_NONE;
         fa_q <= FWD_REG;
         fb_q <= FWD_REG;
      end else begin
         e_q  <= e_d;
         m_q  <= m_d;
         w_q  <= w_d;
         fa_q <= fa_d;
         fb_q <= fb_d;
      end
   end

   div_stall_counter #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_div_cnt (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .busy   (busy)
   );

   assign hz.forward_ae = fa_q;
   assign hz.forward_be = fb_q;
   assign hz.stall_f    = stall_f;
   assign hz.stall_d    = stall_d;
   assign hz.stall_e    = stall_e;
   assign hz.flush_e    = flush_e;
   assign hz.flush_m    = flush_m;
   assign hz.div_busy   = busy;
   assign hz.wb_tag     = w_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It tracks destination-register tags through the E, M and W stages and produces registered 2-bit forwarding selects for the two execute-stage operand multiplexers. It detects load-use hazards and inserts bubbles, and freezes the front of the pipeline for the duration of a fixed-latency divide. It sits between decode and the execute-stage operand muxes, and drives their select inputs directly.

## Interface
Parameters:
- DIV_CYCLES, 32: number of cycles a divide occupies E beyond its entry cycle (≥2).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- id_valid  in  1  D stage holds a real instruction.
- rs_d, rt_d  in  5 each  source register numbers of the D-stage instruction.
- id_writereg  in  5  destination register of the D-stage instruction.
- id_regwrite  in  1  D-stage instruction writes the register file.
- id_memtoreg  in  1  D-stage instruction is a load.
- id_div  in  1  D-stage instruction is DIV/DIVU.
- forward_ae, forward_be  out  2 each  registered operand selects for the E stage: 00 = register-file value, 01 = W-stage result, 10 = M-stage result, 11 = never driven.
- stall_f, stall_d  out  1 each  hold the PC and the F/D register.
- stall_e  out  1  hold the D/E register.
- flush_e  out  1  load a bubble into the D/E register.
- flush_m  out  1  load a bubble into the E/M register.
- div_busy  out  1  a divide is occupying E.

## Operation
- **Internal tags.** E, M and W each hold a tag {valid, writereg, regwrite, memtoreg}. The E tag also carries an is_div bit.
- **Normal advance** (no stall):
  - The E tag loads the D inputs, valid = id_valid.
  - The M tag loads the E tag.
  - The W tag loads the M tag.
- **Forward select for rs_d** (rt_d is handled identically), computed combinationally in D and registered into forward_ae/forward_be when D advances into E:
  - Register 0 never matches; the result is 00.
  - If E is valid with regwrite set and E.writereg == rs_d, the result is 10, because the producer will be in M.
  - Otherwise, if M is valid with regwrite set and M.writereg == rs_d, the result is 01, because the producer will be in W.
  - Otherwise the result is 00.
  - When E is the nearer match, it takes priority over M.
- **Load-use hazard.**
  - Condition: id_valid, E is valid with memtoreg and regwrite set, E.writereg ≠ 0, and E.writereg equals rs_d or rt_d.
  - Response: stall_f = stall_d = flush_e = 1.
  - The E tag becomes a bubble and the forward selects register 00. M and W advance.
  - On the following cycle the selects recompute with the load now in M and resolve to 01.
- **Divide.**
  - When a valid instruction with id_div set advances into E, the counter loads DIV_CYCLES and div_busy rises on the next cycle.
  - While div_busy: stall_f = stall_d = stall_e = flush_m = 1 and flush_e = 0.
  - The E tag and forward selects hold; M takes a bubble; W advances.
  - The counter decrements each cycle; div_busy falls after the cycle in which the counter reaches 1.
  - The divider captures its operands on the first E cycle. Selects held after that cycle are don't-care.
- **Priority.** div_busy overrides load-use, so flush_e = 0 while busy.
  - A divide that is itself load-use stalled does not start until it actually advances.
- **Scope.** The register file writes on the falling edge, so no W→D bypass exists in this block.

## Timing
- Reset (asynchronous, resetn = 0): all tags invalid, counter 0, forward_ae = forward_be = 00, all stall and flush outputs 0, div_busy 0.
- Deasserting resetn mid-divide is not a special case: reset state takes effect immediately and the divide is abandoned.
- Stall and flush outputs are combinational from the tags, the D inputs and the counter. They are valid within the same cycle.
- Forward selects have one cycle of latency: they are registered at the D→E edge and are stable for the whole E cycle.
- A load-use hazard stalls for exactly 1 cycle.
- A divide stalls for exactly DIV_CYCLES cycles.
- Back-to-back divides: a second div in D advances on the cycle div_busy falls, and reloads the counter with no gap.

## Structure
- The shared package `fwd_pkg` holds:
  - the constants FWD_REG = 2'b00, FWD_WB = 2'b01 and FWD_MEM = 2'b10, also used by the operand-mux instantiation;
  - the stage-tag typedef.
- Sub-module `div_stall_counter`:
  - inputs: clk, resetn, start, and DIV_CYCLES;
  - output: busy;
  - contains the down-counter.

## Test plan
- Reset asserted mid-divide (counter = 10): all outputs 0 and div_busy 0 immediately, with no clock edge required.
- ADD $3 in E, then SUB using $3 in D: the next cycle gives forward_ae = 10. With one independent instruction between them, forward_ae = 01 instead.
- LW $5 in E, then ADD using $5 as rt in D: stall_f = stall_d = flush_e = 1 for one cycle. The next cycle gives forward_be = 01 and no stall.
- Write to $0 by the preceding ALU instruction, with the consumer reading $0: forward_ae stays 00.
- DIV with DIV_CYCLES = 4, followed by ADD: div_busy = 1 for exactly 4 cycles, stall_e = flush_m = 1 throughout, and ADD enters E on cycle 5.
- LW $2, then DIV reading $2: there is a 1-cycle load-use stall first. The divide then enters E with forward_ae = 01, and div_busy follows.
